instr_fetch: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the IF/ID register. It owns the PC, issues word requests to instruction memory over a request/response handshake, and presents one `Instruction`/`PC_IF` pair per cycle to IF/ID. It stalls on the same `hold` that freezes IF/ID, and absorbs a returning word in a 1-entry skid buffer while held. It redirects to branch/jump targets, discarding stale in-flight fetches, and raises `flush_IFID` whenever it has no valid instruction to hand over.

---
 rtl/instr_fetch.sv | 68 ++++++
 tb/tb_instr_fetch.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS IF stage owning the PC, one-outstanding imem handshake, 1-entry skid buffer and redirect
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC_IF,
  output logic        flush_IFID
);
  logic [31:0] r_pc, r_req_pc, r_buf_instr, r_buf_pc;
  logic        r_outstanding, r_drop, r_buf_valid;
  logic        w_live_resp, w_slot_free, w_accept, w_capture;
  logic [31:0] w_redirect_addr;
  always_comb begin
    w_live_resp = imem_rvalid & ~r_drop;
    w_slot_free = ~r_outstanding | imem_rvalid;
    w_redirect_addr = {redirect_pc[31:2], 2'b00};
    imem_addr = redirect_valid ? w_redirect_addr : {r_pc[31:2], 2'b00};
    imem_req = reset & w_slot_free & (redirect_valid | (~r_buf_valid & ~(hold & w_live_resp)));
    w_accept = imem_req & imem_ready;
    w_capture = ~redirect_valid & hold & w_live_resp & ~r_buf_valid;
    flush_IFID = redirect_valid | ~(r_buf_valid | w_live_resp);
    Instruction = r_buf_valid ? r_buf_instr : w_live_resp ? imem_rdata : '0;
    PC_IF = r_buf_valid ? r_buf_pc : w_live_resp ? r_req_pc : '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
      r_req_pc <= '0;
      r_outstanding <= 1'b0;
    end else if (w_accept) begin
      r_req_pc <= imem_addr;
      r_pc <= imem_addr + 32'd4;
      r_outstanding <= 1'b1;
    end else begin
      if (imem_rvalid) r_outstanding <= 1'b0;
      if (redirect_valid) r_pc <= w_redirect_addr;
    end
  end
  // a redirect that cannot issue yet marks the pending response stale
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_drop <= 1'b0;
    else r_drop <= (redirect_valid & ~w_accept & r_outstanding & ~imem_rvalid) ? 1'b1 :
                   imem_rvalid ? 1'b0 : r_drop;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf_valid <= 1'b0;
      r_buf_instr <= '0;
      r_buf_pc <= '0;
    end else begin
      r_buf_valid <= ~redirect_valid & (r_buf_valid ? hold : hold & w_live_resp);
      if (w_capture) begin
        r_buf_instr <= imem_rdata;
        r_buf_pc <= r_req_pc;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random checks of instr_fetch against an in-order instruction-stream model
module tb_instr_fetch;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hold = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] Instruction, PC_IF;
  logic        flush_IFID;
  int          errors = 0;
  int          checks = 0;
  int          consumed = 0;
  logic        m_busy = 1'b0;
  logic [31:0] m_addr = '0;
  int          m_cnt = 0;
  logic [31:0] exp_pc = RST_PC;
  logic        s_req, s_flush;
  logic [31:0] s_addr, s_pc, s_ins;

  instr_fetch dut (
    .clk(clk), .reset(reset), .hold(hold),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .Instruction(Instruction), .PC_IF(PC_IF), .flush_IFID(flush_IFID)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // one clock: drive inputs, let memory respond, check the stream, advance the models
  task automatic cyc(input logic h, input logic rv, input logic [31:0] rpc, input logic rdy, input int lat);
    logic acc, rsp;
    hold = h;
    redirect_valid = rv;
    redirect_pc = rpc;
    imem_ready = rdy;
    rsp = m_busy && m_cnt == 0;
    imem_rvalid = rsp;
    imem_rdata = rsp ? word_at(m_addr) : $urandom;
    #1;
    s_req = imem_req;
    s_addr = imem_addr;
    s_flush = flush_IFID;
    s_pc = PC_IF;
    s_ins = Instruction;
    if (!s_flush) begin
      chk("pc_order", s_pc, exp_pc);
      chk("instr_word", s_ins, word_at(exp_pc));
    end else if (!rv) begin
      chk("bubble_pc", s_pc, 32'h0);
      chk("bubble_instr", s_ins, 32'h0);
    end
    if (rv) chk("redirect_flush", {31'b0, s_flush}, 32'h1);
    if (s_req) chk("addr_align", {30'b0, s_addr[1:0]}, 32'h0);
    acc = s_req & rdy;
    if (acc) chk("single_outstanding", {31'b0, m_busy & ~rsp}, 32'h0);
    @(posedge clk);
    if (rsp) m_busy = 1'b0;
    else if (m_busy) m_cnt--;
    if (acc) begin
      m_busy = 1'b1;
      m_addr = s_addr;
      m_cnt = lat - 1;
    end
    if (rv) exp_pc = {rpc[31:2], 2'b00};
    else if (!s_flush && !h) begin
      exp_pc += 32'd4;
      consumed++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    hold = 1'b0;
    redirect_valid = 1'b0;
    m_busy = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_pc", PC_IF, 32'h0);
    chk("rst_flush", {31'b0, flush_IFID}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_pc = RST_PC;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    cyc(0, 0, 0, 1, 1);
    chk("boot_req", {31'b0, s_req}, 32'h1);
    chk("boot_addr", s_addr, RST_PC);
    chk("boot_flush", {31'b0, s_flush}, 32'h1);
    cyc(0, 0, 0, 1, 1);
    chk("first_pc", s_pc, 32'h0040_0000);
    chk("first_valid", {31'b0, s_flush}, 32'h0);
    chk("next_addr", s_addr, 32'h0040_0004);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1, 1);
      chk("hold_pc", s_pc, 32'h0040_0004);
      chk("hold_req", {31'b0, s_req}, 32'h0);
    end
    cyc(0, 0, 0, 1, 1);
    chk("drain_pc", s_pc, 32'h0040_0004);
    chk("drain_req", {31'b0, s_req}, 32'h0);
    cyc(0, 0, 0, 1, 3);
    chk("resume_req", {31'b0, s_req}, 32'h1);
    chk("resume_addr", s_addr, 32'h0040_0008);
    cyc(0, 1, 32'h0040_0100, 1, 1);
    chk("redir_busy_req", {31'b0, s_req}, 32'h0);
    cyc(0, 0, 0, 1, 1);
    chk("redir_wait_flush", {31'b0, s_flush}, 32'h1);
    cyc(0, 0, 0, 1, 1);
    chk("stale_flush", {31'b0, s_flush}, 32'h1);
    chk("stale_req", {31'b0, s_req}, 32'h1);
    chk("redir_addr", s_addr, 32'h0040_0100);
    cyc(0, 0, 0, 1, 1);
    chk("redir_pc", s_pc, 32'h0040_0100);
    cyc(1, 0, 0, 1, 1);
    chk("fill_pc", s_pc, 32'h0040_0104);
    cyc(1, 1, 32'h0040_0103, 1, 1);
    chk("redir_buf_req", {31'b0, s_req}, 32'h1);
    chk("redir_buf_addr", s_addr, 32'h0040_0100);
    cyc(0, 0, 0, 0, 1);
    chk("redir_buf_pc", s_pc, 32'h0040_0100);
    chk("stall_addr0", s_addr, 32'h0040_0104);
    cyc(0, 0, 0, 0, 1);
    chk("stall_req1", {31'b0, s_req}, 32'h1);
    chk("stall_addr1", s_addr, 32'h0040_0104);
    cyc(0, 0, 0, 1, 1);
    chk("stall_addr2", s_addr, 32'h0040_0104);
    cyc(0, 0, 0, 1, 1);
    chk("stall_pc", s_pc, 32'h0040_0104);
    cyc(0, 0, 0, 1, 1);
    chk("pre_reset_pc", s_pc, 32'h0040_0108);
    do_reset();
    cyc(0, 0, 0, 1, 1);
    chk("restart_addr", s_addr, RST_PC);
    cyc(0, 0, 0, 1, 1);
    chk("restart_pc", s_pc, RST_PC);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 15) == 0,
          RST_PC + ($urandom & 32'hFFF), $urandom_range(0, 3) != 0, $urandom_range(1, 3));
    end
    chk("progress", {31'b0, consumed > 500}, 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
